// File: rtl/therm_pkg.sv
// Shared helpers for the thermometer-to-binary encoder.
// tw(bits): thermometer width for a code width; clog2(n): ceil(log2(n)).
package therm_pkg;

    function automatic int tw(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/therm_search.sv
// Combinational thermometer search: optional bubble repair, then
// code = index of highest set bit + 1 (0 when no bit is set).
// Macro THERM_BUBBLE_EN enables 3-input majority repair of each bit.
// Ports: y  [tw(BITS)-1:0] corrected-or-raw thermometer word in
//        code [BITS-1:0]   binary code out
module therm_search
    import therm_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic [tw(BITS)-1:0] y,
    output logic [BITS-1:0]     code
);

    localparam int TW = tw(BITS);

    logic [TW-1:0] c;

`ifdef THERM_BUBBLE_EN
    // Pad below with 1 and above with 0 so the end comparators
    // vote with a virtual "always tripped" / "never tripped" neighbour.
    logic [TW+1:0] ext;

    assign ext = {1'b0, y, 1'b1};

    always_comb begin
        c = '0;
        for (int i = 0; i < TW; i++) begin
            c[i] = (ext[i] & ext[i+1]) |
                   (ext[i] & ext[i+2]) |
                   (ext[i+1] & ext[i+2]);
        end
    end
`else
    assign c = y;
`endif

    // Later iterations override earlier ones: highest set bit wins.
    always_comb begin
        code = '0;
        for (int i = 0; i < TW; i++) begin
            if (c[i]) code = BITS'(i + 1);
        end
    end

endmodule

// File: rtl/therm_enc_pipe.sv
// Pipelined thermometer-to-binary encoder with optional averaging.
// Ports: clk, rst (sync, active high), sample_en, y[TW-1:0] in;
//        b[BITS-1:0], b_valid (1-cycle pulse), ovr (full scale) out.
// Macro THERM_BUBBLE_EN enables bubble repair in therm_search.
module therm_enc_pipe
    import therm_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int OSR_LOG2 = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [tw(BITS)-1:0] y,
    output logic [BITS-1:0]     b,
    output logic                b_valid,
    output logic                ovr
);

    localparam int TW = tw(BITS);

    logic [TW-1:0]   y_s1;
    logic            v1;
    logic [BITS-1:0] code_c;
    logic [BITS-1:0] code_s2;
    logic            sat_s2;
    logic            v2;

    // Stage 1: capture
    always_ff @(posedge clk) begin
        if (rst) begin
            y_s1 <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= sample_en;
            if (sample_en) y_s1 <= y;
        end
    end

    therm_search #(
        .BITS(BITS)
    ) u_search (
        .y    (y_s1),
        .code (code_c)
    );

    // Stage 2: encode. Saturation flag uses the raw word so a repaired
    // top bit cannot mask a genuine full-scale sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_s2 <= '0;
            sat_s2  <= 1'b0;
            v2      <= 1'b0;
        end else begin
            code_s2 <= code_c;
            sat_s2  <= &y_s1;
            v2      <= v1;
        end
    end

    // Stage 3: output, direct or windowed average
    if (OSR_LOG2 == 0) begin : g_direct
        always_ff @(posedge clk) begin
            if (rst) begin
                b       <= '0;
                ovr     <= 1'b0;
                b_valid <= 1'b0;
            end else if (v2) begin
                b       <= code_s2;
                ovr     <= sat_s2;
                b_valid <= 1'b1;
            end else begin
                b_valid <= 1'b0;
            end
        end
    end else begin : g_avg
        // 2^OSR_LOG2 codes of at most 2^BITS-1 fit in BITS+OSR_LOG2 bits.
        localparam int AW = BITS + OSR_LOG2;

        logic [AW-1:0]       acc;
        logic [AW-1:0]       sum;
        logic [OSR_LOG2-1:0] cnt;
        logic                sat_acc;

        assign sum = acc + AW'(code_s2);

        always_ff @(posedge clk) begin
            if (rst) begin
                b       <= '0;
                ovr     <= 1'b0;
                b_valid <= 1'b0;
                acc     <= '0;
                cnt     <= '0;
                sat_acc <= 1'b0;
            end else begin
                b_valid <= 1'b0;
                if (v2) begin
                    if (&cnt) begin
                        b       <= sum[AW-1:OSR_LOG2];
                        ovr     <= sat_acc | sat_s2;
                        b_valid <= 1'b1;
                        acc     <= '0;
                        cnt     <= '0;
                        sat_acc <= 1'b0;
                    end else begin
                        acc     <= sum;
                        cnt     <= cnt + 1'b1;
                        sat_acc <= sat_acc | sat_s2;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_therm_enc_pipe.sv
// Scoreboard bench for therm_enc_pipe: one direct (OSR_LOG2=0) and one
// averaging (OSR_LOG2=2) instance driven by the same stimulus.
module tb_therm_enc_pipe;

    localparam int BITS = 4;
    localparam int TW   = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sample_en = 1'b0;
    logic [TW-1:0]   y = '0;
    logic [BITS-1:0] b0, b2;
    logic            v0, v2, o0, o2;

    always #5 clk = ~clk;

    therm_enc_pipe #(.BITS(BITS), .OSR_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .y(y),
        .b(b0), .b_valid(v0), .ovr(o0)
    );

    therm_enc_pipe #(.BITS(BITS), .OSR_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .y(y),
        .b(b2), .b_valid(v2), .ovr(o2)
    );

    typedef struct {
        int b;
        int ovr;
        int due;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    int   cyc = 0;
    logic rst_q = 1'b0;
    int   win_n = 0;
    int   win_sum = 0;
    int   win_sat = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic v2_prev = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    // Reference: apply the majority vote (if enabled) on the word as a
    // set of comparator outputs, then report the highest tripped level.
    function automatic int ref_code(input logic [TW-1:0] w);
        int lvl[TW];
        int lo, hi, votes;
        for (int i = 0; i < TW; i++) lvl[i] = int'(w[i]);
`ifdef THERM_BUBBLE_EN
        for (int i = 0; i < TW; i++) begin
            lo = (i == 0) ? 1 : int'(w[i-1]);
            hi = (i == TW - 1) ? 0 : int'(w[i+1]);
            votes = lo + int'(w[i]) + hi;
            lvl[i] = (votes >= 2) ? 1 : 0;
        end
`endif
        for (int i = TW - 1; i >= 0; i--) begin
            if (lvl[i] != 0) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [TW-1:0] therm(input int k);
        logic [TW-1:0] w;
        w = '0;
        for (int i = 0; i < k; i++) w[i] = 1'b1;
        return w;
    endfunction

    task automatic clear_model();
        q0.delete();
        q2.delete();
        win_n = 0;
        win_sum = 0;
        win_sat = 0;
    endtask

    task automatic issue(input logic [TW-1:0] w, input int gap);
        int c;
        int s;
        exp_t e;
        @(posedge clk);
        #1;
        sample_en = 1'b1;
        y = w;
        c = ref_code(w);
        s = (w == {TW{1'b1}}) ? 1 : 0;
        e.b = c;
        e.ovr = s;
        e.due = cyc + 3;
        q0.push_back(e);
        win_sum += c;
        win_sat |= s;
        win_n++;
        if (win_n == 4) begin
            e.b = win_sum / 4;
            e.ovr = win_sat;
            q2.push_back(e);
            win_n = 0;
            win_sum = 0;
            win_sat = 0;
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
            sample_en = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sample_en = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sample_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            clear_model();
        end
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops and compares whenever a DUT presents b_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            chk("reset_outputs", int'({b0, v0, o0, b2, v2, o2}), 0);
            v2_prev = 1'b0;
        end else begin
            if (v0) begin
                chk("osr0_expected_pending", int'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("osr0_b", int'(b0), e.b);
                    chk("osr0_ovr", int'(o0), e.ovr);
                    chk("osr0_latency", cyc, e.due);
                end
            end
            if (v2) begin
                chk("osr2_expected_pending", int'(q2.size() > 0), 1);
                chk("osr2_valid_gap", int'(v2_prev), 0);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    chk("osr2_b", int'(b2), e.b);
                    chk("osr2_ovr", int'(o2), e.ovr);
                    chk("osr2_latency", cyc, e.due);
                end
            end
            v2_prev = v2;
        end
    end

    initial begin
        logic [TW-1:0] w;
        int k;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        issue(15'h007F, 0);
        idle(5);
        issue(15'h7FFF, 0);
        issue(15'h0000, 0);
        idle(5);
        issue(15'h00BF, 0);
        issue(15'h0403, 0);
        idle(5);

        do_reset(1);
        issue(therm(3), 0);
        issue(therm(4), 1);
        issue(therm(5), 2);
        issue(therm(6), 3);
        idle(5);
        issue(15'h7FFF, 0);
        issue(15'h7FFF, 0);
        issue(15'h7FFF, 1);
        issue(15'h3FFF, 0);
        idle(5);

        issue(therm(2), 0);
        issue(therm(9), 0);
        idle(4);
        do_reset(1);
        for (int i = 0; i < 4; i++) issue(15'h00FF, i % 2);
        idle(5);

        issue(15'h7FFF, 0);
        #0;
        rst = 1'b1;
        @(posedge clk);
        clear_model();
        #1;
        rst = 1'b0;
        sample_en = 1'b0;
        idle(3);

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0, 1: w = therm(k);
                2: w = therm(k) ^ (TW'(1) << $urandom_range(0, TW - 1));
                default: w = TW'($urandom);
            endcase
            issue(w, ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3));
            if ($urandom_range(0, 79) == 0) do_reset($urandom_range(1, 2));
        end
        idle(10);

        chk("osr0_queue_drained", q0.size(), 0);
        chk("osr2_queue_drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/therm_enc_pipe.md
# therm_enc_pipe

Parametrised, pipelined thermometer-to-binary encoder for the flash ADC back end. It samples the raw comparator thermometer word on a strobe, optionally repairs single bubbles, encodes to binary, and optionally averages 2^OSR_LOG2 conversions before presenting a registered code with a one-cycle valid pulse. It replaces the fixed 15-to-4 encoder between `pre_therm` and the digital output in `adc`.

## Interface
- `BITS`, 4: output code width; thermometer width is TW = 2^BITS − 1.
- `OSR_LOG2`, 0: log2 of samples averaged per output; 0 disables averaging. Legal range 0..4.

- `clk`  input  1: sole clock, rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `sample_en`  input  1: sample strobe; `y` is captured on every edge where it is high.
- `y`  input  TW: thermometer word; `y[0]` is the lowest comparator.
- `b`  output  BITS: binary code, registered.
- `b_valid`  output  1: one-cycle pulse; `b` and `ovr` are new.
- `ovr`  output  1: at least one sample in the window was all-ones (full scale).

## Operation
- Stage 1, capture: if `sample_en`, register `y` → `y_s1` and set `v1=1`; else `v1=0`.
- Stage 2, encode: correct bubbles (see Configuration), then code = (index of highest set bit)+1, or 0 if none set. Register the code and `sat = &y_s1` (raw). Set `v2=v1`.
- Stage 3, output:
  - OSR_LOG2=0: on `v2`, `b<=code`, `ovr<=sat`, `b_valid<=1`; else `b_valid<=0`, `b`/`ovr` hold.
  - OSR_LOG2>0: accumulator `acc` (BITS+OSR_LOG2 bits, cannot overflow), counter `cnt` (OSR_LOG2 bits), sticky `sat_acc`. On `v2`, when `cnt` is not all-ones: `acc+=code`, `cnt++`, `sat_acc|=sat`. When `cnt` is all-ones (last sample): `b<=(acc+code)>>OSR_LOG2` (truncate), `ovr<=sat_acc|sat`, `b_valid<=1`, then `acc<=0`, `cnt<=0` (wrap), `sat_acc<=0`.
- Gaps in `sample_en` are allowed; a window completes after 2^OSR_LOG2 accepted samples regardless of spacing.
- Reset: `b=0`, `b_valid=0`, `ovr=0`, `v1=v2=0`, `acc=0`, `cnt=0`, `sat_acc=0`. Reset mid-window discards the partial sum. Samples in flight are dropped. The first window after reset starts at the first `sample_en` with `rst` low.
- `rst` and `sample_en` high on the same edge: reset wins and the sample is dropped.

## Timing
- Full throughput: `sample_en` may be high every cycle.
- OSR_LOG2=0: `y` sampled on the edge ending cycle n, so `b`/`b_valid` are visible in cycle n+3. Fixed latency 3.
- OSR_LOG2>0: `b_valid` is visible 3 cycles after the sampling edge of the last sample in the window.
- `b_valid` is never high two cycles in a row when OSR_LOG2>0. When OSR_LOG2=0 it follows `sample_en` delayed by 3.
- No combinational path from input to output.

## Configuration
- `THERM_BUBBLE_EN` defined: stage 2 applies a 3-input majority to each bit, c[i] = maj(y[i−1], y[i], y[i+1]). Boundaries use y[−1]=1 and y[TW]=0. This removes isolated single-bit bubbles and sparkles before the search.
- Undefined: the raw `y_s1` feeds the highest-set-bit search directly, so a sparkle produces its index+1. Latency is the same in both builds.

## Structure
- Package `therm_pkg`: `localparam`-style function `tw(bits)` = 2^bits−1, `clog2` helper, and a typedef for code width is not required; keep the functions only.
- One sub-module, `therm_search`. It is combinational: a TW-bit corrected word in, a BITS-bit code out. It holds the bubble logic under the macro and the priority search. The parent owns all registers.

## Test plan
- BITS=4, OSR_LOG2=0: y=15'h007F with `sample_en` pulsed in cycle 5 → `b=7`, `b_valid` high in cycle 8 only, `ovr=0`.
- y=15'h7FFF, then 15'h0000 back-to-back → `b=15` with `ovr=1`, next cycle `b=0` with `ovr=0`. `b_valid` is high for both cycles.
- Bubble: y=15'h00BF (bit 6 low, bit 7 high) → `b=7` with `THERM_BUBBLE_EN`, `b=8` without. Sparkle y=15'h0403 → `b=2` with, `b=11` without.
- OSR_LOG2=2: codes 3,4,5,6 with gaps of 0–3 idle cycles → one `b_valid`, `b=4` (18>>2). Codes 15,15,15,14 → `b=14`, `ovr=1`.
- OSR_LOG2=2: two samples, then `rst` for 1 cycle, then codes 8,8,8,8 → `b=8`, no `b_valid` before the fourth post-reset sample. All outputs are 0 during reset.
